// File: rtl/prbs_lane_checker.sv
// ============================================================================
// Module      : prbs_lane_checker
// Description : Self-synchronising PRBS7/15/31 bit-error-rate checker.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module prbs_lane_checker #(
    parameter int ORDER         = 7,
    parameter int LOCK_COUNT    = 32,
    parameter int WINDOW        = 128,
    parameter int UNLOCK_ERRORS = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_p,
    input  logic        in_n,
    input  logic        stop,
    input  logic        clear,
    output logic        locked,
    output logic        error,
    output logic [63:0] errors,
    output logic [63:0] bits
);

    localparam int TAP     = (ORDER == 7) ? 6 : (ORDER == 15) ? 14 : (ORDER == 31) ? 28 : 0;
    localparam int FILL_W  = $clog2(ORDER + 1);
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int WB_W    = $clog2(WINDOW + 1);
    localparam int WE_W    = $clog2(UNLOCK_ERRORS + 1);

    localparam logic [0:0] ST_SEARCH = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    generate
        if (TAP == 0) begin : g_bad_order
            $error("prbs_lane_checker: ORDER must be 7, 15 or 31");
        end
        if (LOCK_COUNT < ORDER) begin : g_bad_lock_count
            $error("prbs_lane_checker: LOCK_COUNT must be >= ORDER");
        end
    endgenerate

    logic [0:0]         state_q,    state_d;
    logic [ORDER-1:0]   lfsr_q,     lfsr_d;
    logic [FILL_W-1:0]  fill_q,     fill_d;
    logic [MATCH_W-1:0] match_q,    match_d;
    logic [WB_W-1:0]    win_bits_q, win_bits_d;
    logic [WE_W-1:0]    win_errs_q, win_errs_d;
    logic               error_q,    error_d;
    logic [63:0]        errors_q,   errors_d;
    logic [63:0]        bits_q,     bits_d;

    logic               rx;
    logic               invalid;
    logic               pred;
    logic               mismatch;
    logic               filled;
    logic               count_en;
    logic [WB_W-1:0]    win_bits_inc;
    logic [WE_W-1:0]    win_errs_inc;
    logic               unlock;

    assign rx           = in_p;
    assign invalid      = (in_p == in_n);
    assign pred         = lfsr_q[ORDER-1] ^ lfsr_q[TAP-1];
    assign mismatch     = invalid | (rx != pred);
    assign filled       = (fill_q == FILL_W'(ORDER));
    assign count_en     = (state_q == ST_LOCKED) && !stop;
    assign win_bits_inc = win_bits_q + WB_W'(1);
    // Cannot overflow: the unlock fires as soon as the count reaches UNLOCK_ERRORS.
    assign win_errs_inc = win_errs_q + WE_W'(mismatch);
    assign unlock       = count_en && mismatch && (win_errs_inc == WE_W'(UNLOCK_ERRORS));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_SEARCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SEARCH: if (match_d == MATCH_W'(LOCK_COUNT)) state_d = ST_LOCKED;
            ST_LOCKED: if (unlock) state_d = ST_SEARCH;
            default:   state_d = ST_SEARCH;
        endcase
    end

    always_comb begin
        lfsr_d     = lfsr_q;
        fill_d     = fill_q;
        match_d    = match_q;
        win_bits_d = win_bits_q;
        win_errs_d = win_errs_q;
        error_d    = 1'b0;
        errors_d   = errors_q;
        bits_d     = bits_q;

        if (state_q == ST_SEARCH) begin
            lfsr_d = {lfsr_q[ORDER-2:0], rx};
            if (invalid) begin
                fill_d  = '0;
                match_d = '0;
            end else if (!filled) begin
                fill_d  = fill_q + FILL_W'(1);
                match_d = '0;
            end else if ((lfsr_q == '0) || (rx != pred)) begin
                // An all-zero register predicts zeros forever, so it must never build a lock.
                match_d = '0;
            end else begin
                match_d = match_q + MATCH_W'(1);
            end
        end else begin
            // Flywheel on the prediction so a corrupted bit is not fed back.
            lfsr_d = {lfsr_q[ORDER-2:0], pred};
            if (count_en) begin
                bits_d = (bits_q == {64{1'b1}}) ? bits_q : bits_q + 64'd1;
                if (mismatch) begin
                    errors_d = (errors_q == {64{1'b1}}) ? errors_q : errors_q + 64'd1;
                    error_d  = 1'b1;
                end
                if (unlock) begin
                    fill_d     = '0;
                    match_d    = '0;
                    win_bits_d = '0;
                    win_errs_d = '0;
                end else if (win_bits_inc == WB_W'(WINDOW)) begin
                    win_bits_d = '0;
                    win_errs_d = '0;
                end else begin
                    win_bits_d = win_bits_inc;
                    win_errs_d = win_errs_inc;
                end
            end
        end

        if (clear) begin
            errors_d = '0;
            bits_d   = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_q     <= '0;
            fill_q     <= '0;
            match_q    <= '0;
            win_bits_q <= '0;
            win_errs_q <= '0;
            error_q    <= 1'b0;
            errors_q   <= '0;
            bits_q     <= '0;
        end else begin
            lfsr_q     <= lfsr_d;
            fill_q     <= fill_d;
            match_q    <= match_d;
            win_bits_q <= win_bits_d;
            win_errs_q <= win_errs_d;
            error_q    <= error_d;
            errors_q   <= errors_d;
            bits_q     <= bits_d;
        end
    end

    assign locked = (state_q == ST_LOCKED);
    assign error  = error_q;
    assign errors = errors_q;
    assign bits   = bits_q;

endmodule

`default_nettype wire
